// File: rtl/csa_resolver.sv
// csa_resolver: chunked carry-propagate resolver of a save/carry pair; `CSA_RESOLVER_SAT_EN saturates the output
module csa_resolver #(
  parameter int WIDTH = 4,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s_vec,
  input  logic [WIDTH-1:0] c_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             cout
);
  localparam int W2 = WIDTH + 2;
  localparam int N = (W2 + CHUNK - 1) / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RESOLVE, DONE} state_t;
  state_t state, state_n;
  logic [W2-1:0] a, b, res, res_n;
  logic cy, last, cout_n;
  logic [IW-1:0] idx;
  logic [31:0] sh;
  logic [CHUNK-1:0] ac, bc;
  logic [CHUNK:0] cs;
  logic [WIDTH:0] sum_n;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // one chunk of the carry-propagate add, merged into the partial result
  always_comb begin
    sh = 32'(idx) * 32'(CHUNK);
    ac = CHUNK'(a >> sh);
    bc = CHUNK'(b >> sh);
    cs = {1'b0, ac} + {1'b0, bc} + (CHUNK+1)'(cy);
    res_n = res | W2'({{W2{1'b0}}, cs[CHUNK-1:0]} << sh);
    last = idx == IW'(N - 1);
    cout_n = res_n[W2-1];
`ifdef CSA_RESOLVER_SAT_EN
    sum_n = res_n[W2-1] ? '1 : res_n[WIDTH:0];
`else
    sum_n = res_n[WIDTH:0];
`endif
  end
  // next-state logic
  always_comb begin
    state_n = state;
    if (state == IDLE && in_valid) state_n = RESOLVE;
    if (state == RESOLVE && last) state_n = DONE;
    if (state == DONE && out_ready) state_n = IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // operand capture, resolve loop and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      res <= '0;
      cy <= 1'b0;
      idx <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        a <= {2'b0, s_vec};
        b <= {1'b0, c_vec, 1'b0};
        res <= '0;
        cy <= 1'b0;
        idx <= '0;
      end
      if (state == RESOLVE) begin
        res <= res_n;
        cy <= cs[CHUNK];
        idx <= idx + IW'(1);
        if (last) begin
          sum <= sum_n;
          cout <= cout_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: randomized check of csa_resolver against an arithmetic model for CHUNK 2,1,3,6
module tb_csa_resolver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] iv = '0, ir, ov, ordy = '0;
  logic [3:0] sv [4];
  logic [3:0] cv [4];
  logic [4:0] sm [4];
  logic co [4];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    csa_resolver #(.WIDTH(4), .CHUNK(g == 0 ? 2 : g == 1 ? 1 : g == 2 ? 3 : 6)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]),
      .s_vec(sv[g]), .c_vec(cv[g]), .out_valid(ov[g]), .out_ready(ordy[g]),
      .sum(sm[g]), .cout(co[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  function automatic int nsteps(input int k);
    return k == 0 ? 3 : k == 1 ? 6 : k == 2 ? 2 : 1;
  endfunction
  function automatic logic [5:0] model(input logic [3:0] s, input logic [3:0] c);
    int v;
    v = int'(s) + 2 * int'(c);
`ifdef CSA_RESOLVER_SAT_EN
    if (v >= 32) return 6'b111111;
`endif
    return 6'(v);
  endfunction
  task automatic accept_wait(input int k, input logic [3:0] s, input logic [3:0] c);
    int lat;
    sv[k] = s;
    cv[k] = c;
    iv[k] = 1'b1;
    @(posedge clk);
    #1 iv[k] = 1'b0;
    sv[k] = ~s;
    cv[k] = ~c;
    lat = 0;
    while (!ov[k] && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk($sformatf("latency_k%0d", k), lat, nsteps(k));
  endtask
  task automatic run(input int k, input logic [3:0] s, input logic [3:0] c);
    logic [5:0] e;
    e = model(s, c);
    accept_wait(k, s, c);
    chk($sformatf("sum_k%0d_%0d_%0d", k, s, c), 32'(sm[k]), 32'(e[4:0]));
    chk($sformatf("cout_k%0d_%0d_%0d", k, s, c), 32'(co[k]), 32'(e[5]));
    ordy[k] = 1'b1;
    @(posedge clk);
    #1 ordy[k] = 1'b0;
    chk("in_ready_after_take", 32'(ir[k]), 1);
    chk("out_valid_after_take", 32'(ov[k]), 0);
  endtask
  initial begin
    logic [5:0] e;
    for (int i = 0; i < 4; i++) begin
      sv[i] = '0;
      cv[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(ir), 32'hf);
    chk("reset_out_valid", 32'(ov), 0);
    chk("reset_sum", 32'(sm[0]), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(0, 4'b0110, 4'b1011);
    run(0, 4'b1111, 4'b1111);
    e = model(4'b0101, 4'b1110);
    accept_wait(0, 4'b0101, 4'b1110);
    for (int i = 0; i < 5; i++) begin
      iv[0] = i == 2;
      sv[0] = 4'b0001;
      cv[0] = 4'b0001;
      @(posedge clk);
      #1 iv[0] = 1'b0;
      chk("bp_out_valid", 32'(ov[0]), 1);
      chk("bp_in_ready", 32'(ir[0]), 0);
      chk("bp_sum", 32'(sm[0]), 32'(e[4:0]));
      chk("bp_cout", 32'(co[0]), 32'(e[5]));
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    #1 ordy[0] = 1'b0;
    chk("bp_release_in_ready", 32'(ir[0]), 1);
    chk("bp_release_out_valid", 32'(ov[0]), 0);
    sv[0] = 4'b0011;
    cv[0] = 4'b1101;
    iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", 32'(ir[0]), 1);
    chk("rst_mid_out_valid", 32'(ov[0]), 0);
    chk("rst_mid_sum", 32'(sm[0]), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 chk("rst_no_stale", 32'(ov[0]), 0);
    end
    run(0, 4'b0011, 4'b1101);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 10; i++)
        run(k, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
